// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial sequencer for an external 1-bit full adder cell.
// It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
// It presents one operand bit pair per clock, LSB first, together with the
// running carry. It collects each sum bit and the final carry, then holds the
// result on a second valid/ready handshake until the consumer takes it.
module serial_add_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);

   // The bit index always has at least one bit, so WIDTH=1 still gets a legal vector.
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IW-1:0]    idx;
   logic             carry;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;

   logic             accept;
   logic             last_bit;
   logic             cur_a;
   logic             cur_b;

   assign accept   = in_valid && in_ready;
   assign last_bit = (idx == IW'(WIDTH - 1));

   // Select the current operand bits with an explicit compare per bit.
   // This keeps the select in range even when idx is wider than WIDTH needs.
   always_comb begin
      // NOTE: every combinational output gets a default first so that no path leaves it unassigned and infers a latch.
      cur_a = 1'b0;
      cur_b = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (idx == IW'(i)) begin
            cur_a = a_reg[i];
            cur_b = b_reg[i];
         end
      end
   end

   // State register; a synchronous reset returns to IDLE from any state, which aborts the operation.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last bit, DONE -> IDLE on consumer ready.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch the operands on accept, then take one sum bit and the new carry on each RUN edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_reg   <= in_a;
                  b_reg   <= in_b;
                  carry   <= in_cin;
                  idx     <= '0;
                  out_sum <= '0;
               end
            end
            RUN: begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (idx == IW'(i)) begin
                     out_sum[i] <= fa_s;
                  end
               end
               carry <= fa_cout;
               if (last_bit) begin
                  // The index stops at the top bit and never wraps.
                  out_cout <= fa_cout;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: begin
               // DONE holds the result stable until the consumer takes it.
            end
         endcase
      end
   end

   // Output decode: handshake flags come from the state, and the adder inputs are forced to zero outside RUN.
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
      busy      = (state == RUN) || (state == DONE);
      fa_a      = 1'b0;
      fa_b      = 1'b0;
      fa_cin    = 1'b0;
      if (state == RUN) begin
         fa_a   = cur_a;
         fa_b   = cur_b;
         fa_cin = carry;
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl.
// One instance uses WIDTH=4 and a second uses WIDTH=1. Each instance drives
// its own gate-level full adder built here. Expected results are hand-computed
// constants.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   // WIDTH=4 instance signals
   logic       in_valid = 1'b0, in_ready, in_cin = 1'b0;
   logic [3:0] in_a = '0, in_b = '0;
   logic       fa_a, fa_b, fa_cin, fa_s, fa_cout;
   logic       out_valid, out_ready = 1'b0, out_cout, busy;
   logic [3:0] out_sum;

   // WIDTH=1 instance signals
   logic       in_valid1 = 1'b0, in_ready1, in_cin1 = 1'b0;
   logic [0:0] in_a1 = '0, in_b1 = '0;
   logic       fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;
   logic       out_valid1, out_ready1 = 1'b0, out_cout1, busy1;
   logic [0:0] out_sum1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [3:0] tr_a, tr_b, tr_cin;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // gate-level full adder cells
   assign fa_s     = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout  = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
   assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_cin1;
   assign fa_cout1 = (fa_a1 & fa_b1) | (fa_cin1 & (fa_a1 ^ fa_b1));

   serial_add_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .busy(busy)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
      .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
      .out_cout(out_cout1), .busy(busy1)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present operands, wait for the accept edge, then count edges to out_valid and record the RUN trace.
   task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic cin);
      int n;
      int lat;
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("accept_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      tr_a = '0; tr_b = '0; tr_cin = '0;
      while (!out_valid && lat < 20) begin
         if (lat < 4) begin
            tr_a[lat] = fa_a; tr_b[lat] = fa_b; tr_cin[lat] = fa_cin;
         end
         @(posedge clk); #1; lat++;
      end
      check("latency", 32'(lat), 32'd4);
   endtask

   // Check the held result, then complete the output handshake.
   task automatic finish_op(input string name, input logic [3:0] sum, input logic cout);
      check({name, "_sum"}, 32'(out_sum), 32'(sum));
      check({name, "_cout"}, 32'(out_cout), 32'(cout));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_release"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int acc [3];
      logic [3:0] ea [3];
      logic [3:0] eb [3];
      logic [4:0] ex [3];
      int n;

      vecs[0] = '{4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0};
      vecs[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
      vecs[2] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
      vecs[3] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
      vecs[4] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};
      vecs[5] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0};
      vecs[6] = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1};
      vecs[7] = '{4'b1001, 4'b0111, 1'b0, 4'b0000, 1'b1};
      vecs[8] = '{4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0};
      vecs[9] = '{4'b1100, 4'b1010, 1'b1, 4'b0111, 1'b1};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_sum", 32'(out_sum), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
      check("post_rst_cout", 32'(out_cout), 32'd0);

      // test 1 with the full adder input trace (trace bit index = RUN cycle)
      start_op(4'b0011, 4'b0101, 1'b0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_in_ready", 32'(in_ready), 32'd0);
      check("t1_fa_a", 32'(tr_a), 32'(4'b0011));
      check("t1_fa_b", 32'(tr_b), 32'(4'b0101));
      check("t1_fa_cin", 32'(tr_cin), 32'(4'b1110));
      check("t1_fa_idle", 32'({fa_a, fa_b, fa_cin}), 32'd0);
      finish_op("t1", 4'b1000, 1'b0);

      // vector table
      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
         finish_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout);
      end

      // test 3: stall in DONE with ignored in_valid pulses (1001+0101 = 1110)
      start_op(4'b1001, 4'b0101, 1'b0);
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         in_a = 4'hf; in_b = 4'h7; in_cin = 1'b1;
         @(posedge clk); #1;
         check("t3_valid", 32'(out_valid), 32'd1);
         check("t3_sum", 32'(out_sum), 32'(4'b1110));
         check("t3_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      finish_op("t3", 4'b1110, 1'b0);

      // test 4: reset for one cycle at idx=2 of RUN
      check("t4_ready", 32'(in_ready), 32'd1);
      in_a = 4'b1111; in_b = 4'b1111; in_cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t4_busy_mid", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("t4_out_valid", 32'(out_valid), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_in_ready", 32'(in_ready), 32'd1);
      check("t4_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
      check("t4_sum_cleared", 32'(out_sum), 32'd0);
      start_op(4'b0110, 4'b0011, 1'b0);
      finish_op("t4", 4'b1001, 1'b0);

      // test 5: back-to-back with in_valid and out_ready held high
      ea[0] = 4'b0011; eb[0] = 4'b0101; ex[0] = 5'b01000;
      ea[1] = 4'b1111; eb[1] = 4'b0001; ex[1] = 5'b10000;
      ea[2] = 4'b1100; eb[2] = 4'b0010; ex[2] = 5'b01110;
      out_ready = 1'b1;
      in_cin = 1'b0;
      in_a = ea[0]; in_b = eb[0]; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
         end
         check("t5_accept_wait", 32'(n < 50), 32'd1);
         @(posedge clk); #1;
         acc[k] = cyc;
         if (k < 2) begin
            in_a = ea[k+1]; in_b = eb[k+1];
         end else begin
            in_valid = 1'b0;
         end
         n = 0;
         while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
         end
         check($sformatf("t5_latency%0d", k), 32'(n), 32'd4);
         check($sformatf("t5_result%0d", k), 32'({out_cout, out_sum}), 32'(ex[k]));
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t5_spacing01", 32'(acc[1] - acc[0]), 32'd6);
      check("t5_spacing12", 32'(acc[2] - acc[1]), 32'd6);
      check("t5_idle", 32'(busy), 32'd0);

      // test 6: WIDTH=1 exhaustive
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vb;
         logic [1:0] exp1;
         vb = 3'(v);
         exp1 = 2'(vb[2]) + 2'(vb[1]) + 2'(vb[0]);
         in_a1 = vb[2]; in_b1 = vb[1]; in_cin1 = vb[0]; in_valid1 = 1'b1;
         n = 0;
         while (!in_ready1 && n < 50) begin
            @(posedge clk); #1; n++;
         end
         @(posedge clk); #1;
         in_valid1 = 1'b0;
         n = 0;
         while (!out_valid1 && n < 20) begin
            @(posedge clk); #1; n++;
         end
         check($sformatf("w1_latency%0d", v), 32'(n), 32'd1);
         check($sformatf("w1_result%0d", v), 32'({out_cout1, out_sum1}), 32'(exp1));
         out_ready1 = 1'b1;
         @(posedge clk); #1;
         out_ready1 = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
